// File: rtl/display_mux_if.sv
// Signal bundle between the two-digit switch source and the multiplexed seven-segment driver.
// No handshake: digits are level inputs sampled at capture edges; display outputs are continuous levels.
interface display_mux_if;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_tick;
    logic [1:0] dbg_state;

    modport master (
        output digit0, digit1,
        input  seg, an, frame_tick, dbg_state
    );

    modport slave (
        input  digit0, digit1,
        output seg, an, frame_tick, dbg_state
    );
endinterface

// File: rtl/display_mux.sv
// Time-multiplexed dual common-anode seven-segment driver with blanking gaps between digits.
// Outputs are decoded from registered state only, so reset darkens the display asynchronously.
module display_mux #(
    parameter int SHOW_CYCLES  = 24000,
    parameter int BLANK_CYCLES = 240
) (
    input  logic              clk,
    input  logic              reset,
    display_mux_if.slave      bus
);
    localparam int MAXC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        BLANK_A = 2'd0,
        SHOW0   = 2'd1,
        BLANK_B = 2'd2,
        SHOW1   = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic [3:0]    r_digit;

    logic [6:0]    w_dec;
    logic [6:0]    w_seg;
    logic [1:0]    w_an;
    logic          w_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= BLANK_A;
            r_count <= '0;
            r_digit <= 4'd0;
        end else begin
            case (r_state)
                BLANK_A: begin
                    if (r_count == BLANK_LAST) begin
                        r_state <= SHOW0;
                        r_count <= '0;
                        r_digit <= bus.digit0;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                SHOW0: begin
                    if (r_count == SHOW_LAST) begin
                        r_state <= BLANK_B;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                BLANK_B: begin
                    if (r_count == BLANK_LAST) begin
                        r_state <= SHOW1;
                        r_count <= '0;
                        r_digit <= bus.digit1;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                SHOW1: begin
                    if (r_count == SHOW_LAST) begin
                        r_state <= BLANK_A;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                default: begin
                    r_state <= BLANK_A;
                    r_count <= '0;
                end
            endcase
        end
    end

    // Active-low {g,f,e,d,c,b,a}; lowercase b and d keep them distinct from 8 and 0.
    always_comb begin
        w_dec = 7'b1111111;
        case (r_digit)
            4'h0: w_dec = 7'b1000000;
            4'h1: w_dec = 7'b1111001;
            4'h2: w_dec = 7'b0100100;
            4'h3: w_dec = 7'b0110000;
            4'h4: w_dec = 7'b0011001;
            4'h5: w_dec = 7'b0010010;
            4'h6: w_dec = 7'b0000010;
            4'h7: w_dec = 7'b1111000;
            4'h8: w_dec = 7'b0000000;
            4'h9: w_dec = 7'b0010000;
            4'hA: w_dec = 7'b0001000;
            4'hB: w_dec = 7'b0000011;
            4'hC: w_dec = 7'b1000110;
            4'hD: w_dec = 7'b0100001;
            4'hE: w_dec = 7'b0000110;
            4'hF: w_dec = 7'b0001110;
            default: w_dec = 7'b1111111;
        endcase
    end

    always_comb begin
        w_an   = 2'b11;
        w_seg  = 7'b1111111;
        w_tick = 1'b0;
        case (r_state)
            SHOW0: begin
                w_an   = 2'b10;
                w_seg  = w_dec;
                w_tick = (r_count == '0);
            end
            SHOW1: begin
                w_an  = 2'b01;
                w_seg = w_dec;
            end
            default: begin
                w_an  = 2'b11;
                w_seg = 7'b1111111;
            end
        endcase
    end

    assign bus.seg        = w_seg;
    assign bus.an         = w_an;
    assign bus.frame_tick = w_tick;
    assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_display_mux.sv
// Scoreboard bench for display_mux: a frame-phase model predicts {an,seg,frame_tick} each cycle.
module tb_display_mux;
    localparam int S = 4;
    localparam int B = 2;
    localparam int P = 2 * (S + B);
    localparam logic [9:0] DARK = {2'b11, 7'b1111111, 1'b0};

    logic clk;
    logic reset;
    display_mux_if dm_if ();

    display_mux #(
        .SHOW_CYCLES (S),
        .BLANK_CYCLES(B)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (dm_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] dec_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [9:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         m_phase = 0;
    logic [3:0] m_latch = 4'd0;

    task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] model_out(input int ph, input logic [3:0] lat);
        if (ph < B)                return DARK;
        else if (ph < B + S)       return {2'b10, dec_tbl[lat], ph == B};
        else if (ph < 2 * B + S)   return DARK;
        else                       return {2'b01, dec_tbl[lat], 1'b0};
    endfunction

    function automatic logic [9:0] dut_out();
        return {dm_if.an, dm_if.seg, dm_if.frame_tick};
    endfunction

    // One clock: advance the model at the edge, then present next inputs, then compare mid-cycle.
    task automatic run_cycle(input string tag, input logic [3:0] d0, input logic [3:0] d1);
        logic [9:0] e;
        logic [9:0] g;
        @(posedge clk);
        if (reset) begin
            m_phase = 0;
            m_latch = 4'd0;
            exp_q.push_back(DARK);
        end else begin
            m_phase = (m_phase + 1) % P;
            if (m_phase == B)
                m_latch = dm_if.digit0;
            else if (m_phase == 2 * B + S)
                m_latch = dm_if.digit1;
            exp_q.push_back(model_out(m_phase, m_latch));
        end
        #1;
        dm_if.digit0 = d0;
        dm_if.digit1 = d1;
        @(negedge clk);
        g = dut_out();
        if (exp_q.size() == 0) begin
            check_eq({tag, "_empty_q"}, g, 10'h3ff);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, g, e);
        end
        check_eq("an_never_00", {9'd0, dm_if.an == 2'b00}, 10'd0);
        if (dm_if.an == 2'b11)
            check_eq("dark_seg", {3'd0, dm_if.seg}, {3'd0, 7'b1111111});
    endtask

    task automatic reset_and_restart(input string tag);
        for (int i = 0; i < 3; i++) run_cycle({tag, "_held"}, 4'd3, 4'd0);
        reset = 1'b0;
        for (int i = 0; i < 13; i++) run_cycle({tag, "_restart"}, 4'd3, 4'd0);
    endtask

    initial begin
        reset        = 1'b1;
        dm_if.digit0 = 4'd3;
        dm_if.digit1 = 4'd0;
        #1;
        check_eq("reset_state", dut_out(), DARK);

        reset_and_restart("rst");

        for (int i = 0; i < 2 * P; i++) run_cycle("frame_a5", 4'hA, 4'h5);

        while (m_phase != P - 1) run_cycle("align", 4'h0, 4'h0);
        for (int v = 0; v < 16; v++)
            for (int c = 0; c < P; c++) run_cycle("decode_sweep", 4'(v), 4'h0);

        while (m_phase != P - 1) run_cycle("align", 4'h7, 4'h0);
        for (int c = 0; c < 2 * P; c++) run_cycle("stable_in", (c >= 3) ? 4'h8 : 4'h7, 4'h0);

        while (m_phase != 2 * B + S + 1) run_cycle("to_show1", 4'h6, 4'h9);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_dark", dut_out(), DARK);
        reset_and_restart("arst");

        for (int i = 0; i < 1000; i++)
            run_cycle("random", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
